display_rega_mux: RTL and testbench

DISPLAY_REGA_MUX -- requirements
Module: display_rega_mux

---
 rtl/display_rega_mux.sv | 107 ++++++++++
 tb/tb_display_rega_mux.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/display_rega_mux.sv
// Multiplexed 7-segment driver for irrigation zone status: one digit per zone,
// showing '-', 'A' (sprinkler), 'G' (drip) or a blinking 'E' when both are on.
module display_rega_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_SCANS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  lamp_test,
    input  logic [NUM_DIGITS-1:0] aspersao,
    input  logic [NUM_DIGITS-1:0] gotejamento,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_G     = 7'h3D;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_ALL   = 7'h7F;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;
    logic                  tick;
    logic                  idx_last;
    logic                  asp_bit;
    logic                  got_bit;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            glyph;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign tick     = (presc == PW'(SCAN_DIV - 1));
    assign idx_last = (idx == IW'(NUM_DIGITS - 1));

    // Zone selection by compare rather than variable index keeps NUM_DIGITS=1 clean.
    always_comb begin
        asp_bit = 1'b0;
        got_bit = 1'b0;
        an_sel  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                asp_bit   = aspersao[i];
                got_bit   = gotejamento[i];
                an_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        unique case ({asp_bit, got_bit})
            2'b10:   glyph = GLYPH_A;
            2'b01:   glyph = GLYPH_G;
            2'b11:   glyph = blink_phase ? GLYPH_BLANK : GLYPH_E;
            default: glyph = GLYPH_DASH;
        endcase
    end

    always_comb begin
        seg_next = GLYPH_BLANK;
        an_next  = '0;
        if (lamp_test) begin
            seg_next = GLYPH_ALL;
            an_next  = '1;
        end else if (enable) begin
            seg_next = glyph;
            an_next  = an_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= '0;
            an          <= '0;
            frame_done  <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            frame_done <= tick && idx_last;
            seg        <= seg_next;
            an         <= an_next;
            if (tick)
                idx <= idx_last ? '0 : idx + 1'b1;
            // Blink cadence is driven by completed scans, counted on the pulse itself.
            if (frame_done) begin
                if (frame_cnt == FW'(BLINK_SCANS - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_rega_mux.sv
// Directed bench: 4-digit instance (SCAN_DIV=4, BLINK_SCANS=2) plus a 1-digit instance.
module tb_display_rega_mux;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       lamp_test;
    logic [3:0] aspersao;
    logic [3:0] gotejamento;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;
    logic [6:0] seg1;
    logic [0:0] an1;
    logic       frame_done1;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    int d;
    int f;
    logic [6:0] exp_seg;

    always #5 clk = ~clk;

    display_rega_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_SCANS(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lamp_test(lamp_test),
        .aspersao(aspersao), .gotejamento(gotejamento),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    display_rega_mux #(.NUM_DIGITS(1), .SCAN_DIV(3), .BLINK_SCANS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lamp_test(lamp_test),
        .aspersao(aspersao[0:0]), .gotejamento(gotejamento[0:0]),
        .seg(seg1), .an(an1), .frame_done(frame_done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    function automatic logic [3:0] onehot(input int k);
        return 4'b0001 << k;
    endfunction

    initial begin
        rst_n = 1'b0; enable = 1'b1; lamp_test = 1'b0;
        aspersao = '0; gotejamento = '0;
        #3;
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan: dashes, 4 edges per digit, frame pulse every 16 edges.
        for (int k = 1; k <= 32; k++) begin
            step();
            d = ((e - 1) / 4) % 4;
            chk("idle_an", 32'(an), 32'(onehot(d)));
            chk("idle_seg", 32'(seg), 32'h40);
            chk("idle_fd", 32'(frame_done), 32'((e % 16) == 0));
            chk("n1_an", 32'(an1), 32'h1);
            chk("n1_fd", 32'(frame_done1), 32'((e % 3) == 0));
        end

        aspersao = 4'b0001; gotejamento = 4'b0010;
        for (int k = 33; k <= 64; k++) begin
            step();
            d = ((e - 1) / 4) % 4;
            exp_seg = (d == 0) ? 7'h77 : (d == 1) ? 7'h3D : 7'h40;
            chk("mode_an", 32'(an), 32'(onehot(d)));
            chk("mode_seg", 32'(seg), 32'(exp_seg));
        end

        // Fault on zone 2: 'E' for two frames, blank for two, repeating.
        aspersao = 4'b0100; gotejamento = 4'b0100;
        for (int k = 65; k <= 128; k++) begin
            step();
            d = ((e - 1) / 4) % 4;
            f = (e - 1) / 16;
            exp_seg = (d != 2) ? 7'h40 : (((f / 2) % 2) == 1) ? 7'h00 : 7'h79;
            chk("fault_an", 32'(an), 32'(onehot(d)));
            chk("fault_seg", 32'(seg), 32'(exp_seg));
        end

        aspersao = '0; gotejamento = '0;
        while (e < 134) step();
        chk("mid_an", 32'(an), 32'h2);
        chk("mid_seg_before", 32'(seg), 32'h40);
        aspersao = 4'b0010;
        step();
        chk("mid_seg_after", 32'(seg), 32'h77);

        while (e < 144) step();
        chk("fd_144", 32'(frame_done), 32'h1);
        enable = 1'b0; lamp_test = 1'b1; aspersao = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lamp_seg", 32'(seg), 32'h7F);
            chk("lamp_an", 32'(an), 32'hF);
        end
        lamp_test = 1'b0;
        step();
        chk("off_seg", 32'(seg), 32'h0);
        chk("off_an", 32'(an), 32'h0);
        while (e < 159) step();
        chk("off_fd_159", 32'(frame_done), 32'h0);
        step();
        chk("off_fd_160", 32'(frame_done), 32'h1);

        // Reset asserted inside the digit-3 slot while blink_phase=1.
        enable = 1'b1; aspersao = 4'b0001; gotejamento = 4'b0001;
        while (e < 174) step();
        chk("pre_rst_an", 32'(an), 32'h8);
        chk("pre_rst_seg", 32'(seg), 32'h40);
        #1 rst_n = 1'b0;
        #1;
        chk("async_seg", 32'(seg), 32'h0);
        chk("async_an", 32'(an), 32'h0);
        chk("async_fd", 32'(frame_done), 32'h0);
        chk("async_an1", 32'(an1), 32'h0);
        @(posedge clk);
        #1;
        chk("held_an", 32'(an), 32'h0);
        #4 rst_n = 1'b1;
        e = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("restart_an", 32'(an), 32'((e <= 4) ? 4'b0001 : 4'b0010));
            chk("restart_seg", 32'(seg), 32'((e <= 4) ? 7'h79 : 7'h40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
